// File: rtl/plab5_mcore_mem_net_arb_pkg.sv
// Shared definitions for the two-domain memory network arbiter.
package plab5_mcore_mem_net_arb_pkg;

  // Memory message field widths; the request and response widths are built from them.
  localparam int unsigned MEM_TYPE_NBITS   = 3;
  localparam int unsigned MEM_OPAQUE_NBITS = 8;
  localparam int unsigned MEM_ADDR_NBITS   = 32;
  localparam int unsigned MEM_LEN_NBITS    = 2;
  localparam int unsigned MEM_DATA_NBITS   = 32;

  localparam int unsigned MEM_REQ_NBITS  = MEM_TYPE_NBITS + MEM_OPAQUE_NBITS
                                         + MEM_ADDR_NBITS + MEM_LEN_NBITS + MEM_DATA_NBITS;
  localparam int unsigned MEM_RESP_NBITS = MEM_TYPE_NBITS + MEM_OPAQUE_NBITS
                                         + MEM_LEN_NBITS + MEM_DATA_NBITS;

  // Field layout of the memory messages carried on the ports.
  typedef struct packed {
    logic [MEM_TYPE_NBITS-1:0]   msg_type;
    logic [MEM_OPAQUE_NBITS-1:0] opaque;
    logic [MEM_ADDR_NBITS-1:0]   addr;
    logic [MEM_LEN_NBITS-1:0]    len;
    logic [MEM_DATA_NBITS-1:0]   data;
  } mem_req_msg_t;

  typedef struct packed {
    logic [MEM_TYPE_NBITS-1:0]   msg_type;
    logic [MEM_OPAQUE_NBITS-1:0] opaque;
    logic [MEM_LEN_NBITS-1:0]    len;
    logic [MEM_DATA_NBITS-1:0]   data;
  } mem_resp_msg_t;

  // Security domain of a requester.
  typedef enum logic {
    DOMAIN_P0 = 1'b0,
    DOMAIN_P1 = 1'b1
  } domain_e;

  // Scheduling mode.
  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_TDM = 1'b1
  } mode_e;

endpackage

// File: rtl/plab5_mcore_resp_slot_buf.sv
// One-entry response buffer holding a single memory response for one domain.
module plab5_mcore_resp_slot_buf
  import plab5_mcore_mem_net_arb_pkg::*;
#(
  parameter int unsigned p_nbits = MEM_RESP_NBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic               full;
  logic [p_nbits-1:0] data;

  assign enq_rdy = !full;
  assign deq_val = full;
  assign deq_msg = data;

  // Fill on enqueue, empty on dequeue; the two cannot coincide since enq needs empty, deq needs full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (enq_val && enq_rdy) begin
      full <= 1'b1;
      data <= enq_msg;
    end else if (deq_val && deq_rdy) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_net_arb.sv
// Two-domain memory arbiter: TDM secure scheduling or round-robin, one outstanding request.
module plab5_mcore_mem_net_arb
  import plab5_mcore_mem_net_arb_pkg::*;
#(
  parameter int unsigned p_req_nbits    = MEM_REQ_NBITS,
  parameter int unsigned p_resp_nbits   = MEM_RESP_NBITS,
  parameter int unsigned p_slot_cycles  = 8,
  parameter int unsigned p_issue_window = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,

  input  logic [p_req_nbits-1:0]           req_in_msg_p0,
  input  logic                             req_in_val_p0,
  output logic                             req_in_rdy_p0,
  input  logic [p_req_nbits-1:0]           req_in_msg_p1,
  input  logic                             req_in_val_p1,
  output logic                             req_in_rdy_p1,

  output logic [p_resp_nbits-1:0]          resp_out_msg_p0,
  output logic                             resp_out_val_p0,
  input  logic                             resp_out_rdy_p0,
  output logic [p_resp_nbits-1:0]          resp_out_msg_p1,
  output logic                             resp_out_val_p1,
  input  logic                             resp_out_rdy_p1,

  output logic [p_req_nbits-1:0]           req_out_msg,
  output logic                             req_out_domain,
  output logic                             req_out_val,
  input  logic                             req_out_rdy,

  input  logic [p_resp_nbits-1:0]          resp_in_msg,
  input  logic                             resp_in_val,
  output logic                             resp_in_rdy,

  output logic                             cur_owner,
  output logic [$clog2(p_slot_cycles)-1:0] slot_cnt
);

  localparam int unsigned SLOT_W = $clog2(p_slot_cycles);

  logic outstanding;
  logic tag;
  logic mode_q;
  logic rr_pref;

  logic grant_p0;
  logic grant_p1;
  logic issue;
  logic resp_fire;
  logic slot_last;
  logic in_window;
  logic mode_ld;
  logic mode_nxt;

  logic buf_enq_val_p0;
  logic buf_enq_val_p1;
  logic buf_enq_rdy_p0;
  logic buf_enq_rdy_p1;
  logic buf_val_p0;
  logic buf_val_p1;

  assign slot_last = (slot_cnt == SLOT_W'(p_slot_cycles - 1));
  assign in_window = (32'(slot_cnt) < 32'(p_issue_window));

  // Grant selection; everything is forced off while reset is held so no handshake leaks out.
  always_comb begin
    logic elig_p0;
    logic elig_p1;
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    elig_p0  = !outstanding && !buf_val_p0;
    elig_p1  = !outstanding && !buf_val_p1;
    if (reset) begin
      if (mode_q == MODE_TDM) begin
        if (in_window) begin
          if (cur_owner == DOMAIN_P0) grant_p0 = elig_p0;
          else                        grant_p1 = elig_p1;
        end
      end else begin
        if (req_in_val_p0 && elig_p0 &&
            (!(req_in_val_p1 && elig_p1) || rr_pref == DOMAIN_P0)) begin
          grant_p0 = 1'b1;
        end else if (req_in_val_p1 && elig_p1) begin
          grant_p1 = 1'b1;
        end
      end
    end
  end

  // Request path is a pure combinational pass-through of the granted port.
  assign req_in_rdy_p0  = grant_p0 && req_out_rdy;
  assign req_in_rdy_p1  = grant_p1 && req_out_rdy;
  assign req_out_val    = (grant_p0 && req_in_val_p0) || (grant_p1 && req_in_val_p1);
  assign req_out_domain = grant_p1;
  assign req_out_msg    = grant_p0 ? req_in_msg_p0 :
                          grant_p1 ? req_in_msg_p1 : '0;
  assign issue          = req_out_val && req_out_rdy;

  // Target buffer is always empty while a request is outstanding; the term only documents that.
  assign resp_in_rdy    = outstanding && (tag == DOMAIN_P1 ? buf_enq_rdy_p1 : buf_enq_rdy_p0);
  assign resp_fire      = resp_in_val && resp_in_rdy;
  assign buf_enq_val_p0 = resp_fire && (tag == DOMAIN_P0);
  assign buf_enq_val_p1 = resp_fire && (tag == DOMAIN_P1);

  // Mode only changes with nothing in flight, and in TDM only at the end of a slot.
  assign mode_ld  = !outstanding && ((mode_q == MODE_RR) || slot_last);
  assign mode_nxt = mode_ld ? mode : mode_q;

  // Slot timer, mode register and outstanding-request tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= 1'b0;
      tag         <= DOMAIN_P0;
      mode_q      <= MODE_RR;
      slot_cnt    <= '0;
      cur_owner   <= DOMAIN_P0;
      rr_pref     <= DOMAIN_P0;
    end else begin
      mode_q <= mode_nxt;
      if (mode_nxt == MODE_RR || mode_q == MODE_RR) begin
        slot_cnt  <= '0;
        cur_owner <= DOMAIN_P0;
      end else if (slot_last) begin
        slot_cnt  <= '0;
        cur_owner <= !cur_owner;
      end else begin
        slot_cnt  <= slot_cnt + SLOT_W'(1);
      end
      if (issue) begin
        outstanding <= 1'b1;
        tag         <= req_out_domain;
        rr_pref     <= !req_out_domain;
      end else if (resp_fire) begin
        outstanding <= 1'b0;
      end
    end
  end

  plab5_mcore_resp_slot_buf #(.p_nbits(p_resp_nbits)) resp_buf_p0 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (buf_enq_val_p0),
    .enq_rdy (buf_enq_rdy_p0),
    .enq_msg (resp_in_msg),
    .deq_val (buf_val_p0),
    .deq_rdy (resp_out_rdy_p0),
    .deq_msg (resp_out_msg_p0)
  );

  plab5_mcore_resp_slot_buf #(.p_nbits(p_resp_nbits)) resp_buf_p1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (buf_enq_val_p1),
    .enq_rdy (buf_enq_rdy_p1),
    .enq_msg (resp_in_msg),
    .deq_val (buf_val_p1),
    .deq_rdy (resp_out_rdy_p1),
    .deq_msg (resp_out_msg_p1)
  );

  assign resp_out_val_p0 = buf_val_p0;
  assign resp_out_val_p1 = buf_val_p1;

endmodule

// File: tb/tb_plab5_mcore_mem_net_arb.sv
// Directed scoreboard bench for the two-domain memory arbiter.
module tb_plab5_mcore_mem_net_arb;

  localparam int unsigned REQ_W  = 77;
  localparam int unsigned RESP_W = 45;
  localparam int SLOT   = 8;
  localparam int WINDOW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic [REQ_W-1:0]  req_in_msg_p0, req_in_msg_p1;
  logic              req_in_val_p0, req_in_val_p1;
  logic              req_in_rdy_p0, req_in_rdy_p1;
  logic [RESP_W-1:0] resp_out_msg_p0, resp_out_msg_p1;
  logic              resp_out_val_p0, resp_out_val_p1;
  logic              resp_out_rdy_p0, resp_out_rdy_p1;
  logic [REQ_W-1:0]  req_out_msg;
  logic              req_out_domain, req_out_val, req_out_rdy;
  logic [RESP_W-1:0] resp_in_msg;
  logic              resp_in_val, resp_in_rdy;
  logic              cur_owner;
  logic [2:0]        slot_cnt;

  plab5_mcore_mem_net_arb dut (
    .clk(clk), .reset(reset), .mode(mode),
    .req_in_msg_p0(req_in_msg_p0), .req_in_val_p0(req_in_val_p0), .req_in_rdy_p0(req_in_rdy_p0),
    .req_in_msg_p1(req_in_msg_p1), .req_in_val_p1(req_in_val_p1), .req_in_rdy_p1(req_in_rdy_p1),
    .resp_out_msg_p0(resp_out_msg_p0), .resp_out_val_p0(resp_out_val_p0), .resp_out_rdy_p0(resp_out_rdy_p0),
    .resp_out_msg_p1(resp_out_msg_p1), .resp_out_val_p1(resp_out_val_p1), .resp_out_rdy_p1(resp_out_rdy_p1),
    .req_out_msg(req_out_msg), .req_out_domain(req_out_domain), .req_out_val(req_out_val),
    .req_out_rdy(req_out_rdy),
    .resp_in_msg(resp_in_msg), .resp_in_val(resp_in_val), .resp_in_rdy(resp_in_rdy),
    .cur_owner(cur_owner), .slot_cnt(slot_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Memory model state
  int          lat;
  logic        mem_busy;
  int          mem_wait;
  logic        mem_dom;
  logic [REQ_W-1:0] mem_req;
  logic        val_pend;
  logic        val_pend_dom;
  logic [31:0] seq0, seq1;

  // Scoreboard and issue log
  logic [RESP_W-1:0] exp_q0[$];
  logic [RESP_W-1:0] exp_q1[$];
  int   issue_cyc[$];
  logic issue_dom[$];
  logic tdm_chk;
  int   tdm_t0;
  int   iso_a[$];
  int   iso_b[$];
  int   iso_p0cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [REQ_W-1:0] msg_of(input logic d, input logic [31:0] s);
    return d ? {45'h0FED_CBA9_8765, s} : {45'h0123_4567_89AB, s};
  endfunction

  function automatic logic [RESP_W-1:0] rsp_of(input logic [REQ_W-1:0] r);
    return r[RESP_W-1:0] ^ 45'h0A5A_5A5A_5A5A;
  endfunction

  // One clock cycle: observe fires, step the scoreboard and the memory model.
  task automatic tick();
    logic rq_f, rs_f, o0_f, o1_f;
    int rel;
    #1;
    if (val_pend) begin
      chk("resp_out_val_latency", 128'(val_pend_dom ? resp_out_val_p1 : resp_out_val_p0), 128'(1));
      val_pend = 1'b0;
    end
    if (!mem_busy) chk("resp_in_rdy_idle", 128'(resp_in_rdy), 128'(0));
    rq_f = req_out_val && req_out_rdy;
    rs_f = resp_in_val && resp_in_rdy;
    o0_f = resp_out_val_p0 && resp_out_rdy_p0;
    o1_f = resp_out_val_p1 && resp_out_rdy_p1;
    if (rq_f) begin
      chk("single_outstanding", 128'(mem_busy), 128'(0));
      chk("req_out_msg", 128'(req_out_msg), 128'(req_out_domain ? req_in_msg_p1 : req_in_msg_p0));
      chk("req_in_rdy_granted", 128'(req_out_domain ? req_in_rdy_p1 : req_in_rdy_p0), 128'(1));
      if (tdm_chk) begin
        rel = cyc - tdm_t0;
        chk("tdm_owner", 128'(req_out_domain), 128'((rel / SLOT) % 2));
        chk("tdm_window", 128'((rel % SLOT) < WINDOW), 128'(1));
      end
      if (req_out_domain) exp_q1.push_back(rsp_of(req_in_msg_p1));
      else                exp_q0.push_back(rsp_of(req_in_msg_p0));
      mem_busy = 1'b1;
      mem_wait = lat;
      mem_dom  = req_out_domain;
      mem_req  = req_out_msg;
      issue_cyc.push_back(cyc);
      issue_dom.push_back(req_out_domain);
    end
    if (rs_f) chk("resp_out_val_before", 128'(mem_dom ? resp_out_val_p1 : resp_out_val_p0), 128'(0));
    if (o0_f) begin
      if (exp_q0.size() == 0) chk("resp_p0_unexpected", 128'(1), 128'(0));
      else chk("resp_p0_msg", 128'(resp_out_msg_p0), 128'(exp_q0.pop_front()));
    end
    if (o1_f) begin
      if (exp_q1.size() == 0) chk("resp_p1_unexpected", 128'(1), 128'(0));
      else chk("resp_p1_msg", 128'(resp_out_msg_p1), 128'(exp_q1.pop_front()));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rq_f) begin
      if (mem_dom) begin seq1++; req_in_msg_p1 = msg_of(1'b1, seq1); end
      else         begin seq0++; req_in_msg_p0 = msg_of(1'b0, seq0); end
    end
    if (rs_f) begin
      mem_busy     = 1'b0;
      resp_in_val  = 1'b0;
      resp_in_msg  = '0;
      val_pend     = 1'b1;
      val_pend_dom = mem_dom;
    end else if (mem_busy && !resp_in_val) begin
      if (mem_wait > 1) mem_wait--;
      else begin
        resp_in_val = 1'b1;
        resp_in_msg = rsp_of(mem_req);
      end
    end
  endtask

  task automatic do_reset(input logic m);
    reset = 1'b0;
    mode = 1'b0;
    req_in_val_p0 = 1'b0; req_in_val_p1 = 1'b0;
    req_in_msg_p0 = msg_of(1'b0, seq0); req_in_msg_p1 = msg_of(1'b1, seq1);
    resp_in_val = 1'b0; resp_in_msg = '0;
    mem_busy = 1'b0; mem_wait = 0; val_pend = 1'b0; tdm_chk = 1'b0;
    exp_q0.delete(); exp_q1.delete(); issue_cyc.delete(); issue_dom.delete();
    @(negedge clk);
    @(negedge clk);
    mode = m;
    req_out_rdy = 1'b1;
    resp_out_rdy_p0 = 1'b1;
    resp_out_rdy_p1 = 1'b1;
    reset = 1'b1;
    cyc = 0;
  endtask

  // Enter TDM from reset and record p1 issue times relative to the first TDM cycle.
  task automatic run_iso(input logic p0_busy);
    do_reset(1'b1);
    tick();
    chk("tdm_start_slot", 128'(slot_cnt), 128'(0));
    chk("tdm_start_owner", 128'(cur_owner), 128'(0));
    tdm_t0 = cyc;
    tdm_chk = 1'b1;
    req_in_val_p1 = 1'b1;
    req_in_val_p0 = p0_busy;
    repeat (48) tick();
    iso_p0cnt = 0;
    foreach (issue_cyc[i]) begin
      if (issue_dom[i]) iso_b.push_back(issue_cyc[i] - tdm_t0);
      else iso_p0cnt++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n, p0c, p1c, d;
    logic found;
    seq0 = 0; seq1 = 0; lat = 2; cyc = 0;
    mem_busy = 1'b0; val_pend = 1'b0; tdm_chk = 1'b0;

    // Reset held with every input active: nothing may handshake.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mode = 1'(i); req_out_rdy = 1'b1; resp_in_val = 1'b1;
      req_in_val_p0 = 1'b1; req_in_val_p1 = 1'b1;
      resp_out_rdy_p0 = 1'b1; resp_out_rdy_p1 = 1'b1;
      req_in_msg_p0 = 77'({$urandom, $urandom, $urandom});
      req_in_msg_p1 = 77'({$urandom, $urandom, $urandom});
      resp_in_msg = 45'({$urandom, $urandom});
      #1;
      chk("rst_handshakes", 128'({req_in_rdy_p0, req_in_rdy_p1, req_out_val, resp_in_rdy,
                                  resp_out_val_p0, resp_out_val_p1}), 128'(0));
      chk("rst_msgs", 128'({req_out_msg, resp_out_msg_p0, resp_out_msg_p1}), 128'(0));
      chk("rst_slot_owner", 128'({slot_cnt, cur_owner}), 128'(0));
    end

    // TDM isolation: p1 issue times identical whether p0 idles or saturates.
    run_iso(1'b0);
    iso_a = iso_b;
    iso_b.delete();
    chk("iso_first_p1_issue", 128'(iso_a.size() > 0 ? iso_a[0] : -1), 128'(8));
    chk("iso_p1_count", 128'(iso_a.size()), 128'(3));
    chk("iso_idle_p0_count", 128'(iso_p0cnt), 128'(0));
    run_iso(1'b1);
    chk("iso_busy_p0_count", 128'(iso_p0cnt), 128'(3));
    chk("iso_same_count", 128'(iso_b.size()), 128'(iso_a.size()));
    for (int i = 0; i < iso_a.size() && i < iso_b.size(); i++)
      chk("iso_same_cycle", 128'(iso_b[i]), 128'(iso_a[i]));

    // TDM window: p0 asks at slot 5 and waits for its next slot.
    do_reset(1'b1);
    tick();
    tdm_t0 = cyc;
    tdm_chk = 1'b1;
    repeat (5) tick();
    chk("win_slot_at_request", 128'(slot_cnt), 128'(5));
    req_in_val_p0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (issue_cyc.size() > 0) found = 1'b1;
      else tick();
    end
    chk("win_issue_seen", 128'(found), 128'(1));
    if (found) chk("win_issue_cycle", 128'(issue_cyc[0] - tdm_t0), 128'(16));

    // Round-robin fairness with both domains saturating.
    do_reset(1'b0);
    req_in_val_p0 = 1'b1; req_in_val_p1 = 1'b1;
    repeat (20) tick();
    chk("rr_issue_count", 128'(issue_cyc.size() >= 6), 128'(1));
    if (issue_cyc.size() >= 6) begin
      chk("rr_first_cycle", 128'(issue_cyc[0]), 128'(0));
      for (int i = 0; i < 6; i++) chk("rr_alternate", 128'(issue_dom[i]), 128'(i % 2));
      for (int i = 0; i < 5; i++) chk("rr_spacing", 128'(issue_cyc[i+1] - issue_cyc[i]), 128'(3));
    end
    chk("rr_slot_held", 128'({slot_cnt, cur_owner}), 128'(0));

    // Backpressure: a stuck p0 response blocks only p0.
    do_reset(1'b0);
    resp_out_rdy_p0 = 1'b0;
    req_in_val_p0 = 1'b1; req_in_val_p1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (resp_out_val_p0) found = 1'b1;
      else tick();
    end
    chk("bp_p0_buffered", 128'(found), 128'(1));
    n = issue_cyc.size();
    repeat (12) tick();
    p0c = 0; p1c = 0;
    for (int i = n; i < issue_cyc.size(); i++) begin
      if (issue_dom[i]) p1c++; else p0c++;
    end
    chk("bp_p0_blocked", 128'(p0c), 128'(0));
    chk("bp_p1_served", 128'(p1c >= 3), 128'(1));
    req_in_val_p1 = 1'b0;
    for (int i = 0; i < 10 && mem_busy; i++) tick();
    chk("bp_drained_mem", 128'(mem_busy), 128'(0));
    repeat (2) tick();
    resp_out_rdy_p0 = 1'b1;
    d = cyc;
    n = issue_cyc.size();
    tick();
    tick();
    chk("bp_p0_issue_count", 128'(issue_cyc.size() - n), 128'(1));
    if (issue_cyc.size() > n) begin
      chk("bp_p0_issue_cycle", 128'(issue_cyc[n]), 128'(d + 1));
      chk("bp_p0_issue_dom", 128'(issue_dom[n]), 128'(0));
    end

    // Mode switch requested while a request is outstanding.
    do_reset(1'b0);
    lat = 3;
    req_in_val_p0 = 1'b1;
    tick();
    chk("ms_issued", 128'(mem_busy), 128'(1));
    req_in_val_p0 = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < 10 && mem_busy; i++) begin
      #1;
      chk("ms_slot_held_outstanding", 128'(slot_cnt), 128'(0));
      tick();
    end
    chk("ms_resp_done", 128'(mem_busy), 128'(0));
    chk("ms_slot_f1", 128'(slot_cnt), 128'(0));
    tick();
    chk("ms_slot_f2", 128'({slot_cnt, cur_owner}), 128'(0));
    tick();
    chk("ms_slot_f3", 128'(slot_cnt), 128'(1));
    chk("ms_owner_f3", 128'(cur_owner), 128'(0));
    tick();
    chk("ms_scoreboard_empty", 128'(exp_q0.size() + exp_q1.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_net_arb.md
PLAB5_MCORE_MEM_NET_ARB -- requirements
Module: plab5_mcore_mem_net_arb

Interface
REQ-001 Parameters, each as name, default, meaning; the port widths below use these parameters:
- p_req_nbits, 77: memory request message width.
- p_resp_nbits, 45: memory response message width.
- p_slot_cycles, 8: time-division multiplexing (TDM) slot length in cycles, >=2.
- p_issue_window, 4: TDM cycles per slot in which issue is allowed, 1..p_slot_cycles.
REQ-002 Ports, each as name, direction, width, meaning:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low.
- mode, in, 1: 1 = TDM secure scheduling, 0 = round-robin (RR).
- req_in_msg_p0/p1, in, p_req_nbits: requester messages; domain 0 and domain 1 respectively.
- req_in_val_p0/p1, in, 1; req_in_rdy_p0/p1, out, 1: requester handshake.
- resp_out_msg_p0/p1, out, p_resp_nbits; resp_out_val_p0/p1, out, 1; resp_out_rdy_p0/p1, in, 1: per-domain response delivery.
- req_out_msg, out, p_req_nbits; req_out_domain, out, 1; req_out_val, out, 1; req_out_rdy, in, 1: shared memory request port.
- resp_in_msg, in, p_resp_nbits; resp_in_val, in, 1; resp_in_rdy, out, 1: shared memory response port.
- cur_owner, out, 1; slot_cnt, out, $clog2(p_slot_cycles): TDM status.

Function
REQ-003 A transfer occurs on a val&rdy cycle; the request path is combinational pass-through of the granted port with no request buffering; a fire sets outstanding=1 and tag=granted domain.
REQ-004 The block SHALL allow at most one outstanding memory request in total.
REQ-005 Grant is permitted only when outstanding=0 and resp_buf_valid[domain]=0; req_in_rdy_pX=grant_pX&req_out_rdy; req_out_val=grant&req_in_val of the granted port; req_out_domain=granted domain.
REQ-006 TDM (mode_q=1):
- slot_cnt increments every cycle and wraps from p_slot_cycles-1 to 0; cur_owner toggles on wrap.
- Grant goes only to cur_owner, and only while slot_cnt<p_issue_window.
- Slot timing is independent of traffic from either domain.
REQ-007 RR (mode_q=0):
- slot_cnt and cur_owner are held at 0.
- With one eligible requester, it is granted.
- With both eligible, the domain not served last is granted; the last-served pointer updates on each issue.
REQ-008 resp_in_rdy=outstanding; on a response fire, resp_in_msg is written to resp_buf[tag], resp_buf_valid[tag] is set and outstanding is cleared, all in the same edge. Responses with outstanding=0 are held off (rdy=0).
REQ-009 resp_out_msg_pX=resp_buf[X]; resp_out_val_pX=resp_buf_valid[X]; valid clears on resp_out_rdy_pX. Latency from resp_in fire to resp_out_val is 1 cycle.
REQ-010 Mode changes:
- mode is sampled into mode_q only when outstanding=0 and either (mode_q=1 and slot_cnt=p_slot_cycles-1) or mode_q=0.
- Entering TDM starts at slot_cnt=0, cur_owner=0.
REQ-011 Same-edge events: a response fire and a new issue cannot coincide, because REQ-005 blocks the issue. A buffer dequeue and a buffer fill for the same domain cannot coincide, because of the single outstanding request.
REQ-012 A slot boundary occurring during an outstanding request does not extend the slot; the response is still routed by tag.

Reset
REQ-013 While reset=0, asynchronously: outstanding=0, tag=0, mode_q=0, slot_cnt=0, cur_owner=0, RR pointer=0 (p0 preferred on the first contention), resp_buf_valid=0. All val and rdy outputs are 0; message outputs are 0.
REQ-014 A reset mid-transaction discards the outstanding request and any buffered responses; the memory side is reset concurrently.

Structure
REQ-015 A shared package holds:
- the req/resp message widths derived from the memory-message macros;
- domain encoding (0=p0, 1=p1);
- mode encoding (TDM=1).
REQ-016 One sub-module, plab5_mcore_resp_slot_buf: a one-entry response buffer with enq val/rdy and deq val/rdy, instantiated once per domain.

Verification
REQ-017 Reset: hold reset=0 for 3 cycles with inputs toggling -> all val/rdy outputs 0, slot_cnt=0, cur_owner=0.
REQ-018 TDM isolation (mode=1, p_slot_cycles=8, p_issue_window=4):
- p1 requests continuously from cycle 0 -> first req_out fire with req_out_domain=1 at slot_cnt=0 of cycle 8.
- Identical issue cycles whether p0 is idle or saturated.
REQ-019 TDM window: p0 asserts val at slot_cnt=5 -> no grant until slot_cnt=0 of its next slot (cycle 16).
REQ-020 RR fairness (mode=0): both request continuously, memory response after 2 cycles with rdy=1 -> issues alternate p0,p1,p0,p1; each resp_out_valX rises 1 cycle after the matching resp_in fire.
REQ-021 Backpressure: resp_out_rdy_p0=0 with p0 response buffered -> p0 not granted, p1 still served (RR); after rdy=1, buffer drains and p0 is granted next cycle.
REQ-022 Mode switch: mode 0->1 while outstanding -> mode_q changes only after the response fires; TDM starts at slot_cnt=0, owner=0.
